// File: rtl/hazard_control_unit_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// States are plain 3-bit constants so that older modules can compare against them directly.
package hazard_control_unit_pkg;

    localparam int REG_IDX_W = 5;
    localparam int STALL_CNT_W = 32;

    typedef logic [2:0] hazard_state_t;

    localparam hazard_state_t RUN    = 3'd0;
    localparam hazard_state_t DWAIT  = 3'd1;
    localparam hazard_state_t LSTALL = 3'd2;
    localparam hazard_state_t FLUSH  = 3'd3;
    localparam hazard_state_t HALTED = 3'd4;

endpackage

// File: rtl/hazard_control_unit_if.sv
// Bundle between the pipeline datapath (master) and the hazard controller (slave).
interface hazard_control_unit_if
    import hazard_control_unit_pkg::*;
#(
    parameter int REG_W = REG_IDX_W,
    parameter int CNT_W = STALL_CNT_W
);
    logic             ihit;
    logic             dhit;
    logic             dmemREN_mem;
    logic             dmemWEN_mem;
    logic             memToReg_ex;
    logic [REG_W-1:0] regOut_ex;
    logic [REG_W-1:0] Rs_id;
    logic [REG_W-1:0] Rt_id;
    logic             usesRt_id;
    logic             branch_taken_mem;
    logic             jump_id;
    logic             halt_wb;

    logic             pc_en;
    logic             ifid_en;
    logic             ifid_flush;
    logic             idex_en;
    logic             idex_flush;
    logic             exmem_en;
    logic             exmem_flush;
    logic             memwb_en;
    logic             halted;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output ihit, dhit, dmemREN_mem, dmemWEN_mem, memToReg_ex, regOut_ex,
               Rs_id, Rt_id, usesRt_id, branch_taken_mem, jump_id, halt_wb,
        input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
               exmem_flush, memwb_en, halted, stall_count
    );

    modport slave (
        input  ihit, dhit, dmemREN_mem, dmemWEN_mem, memToReg_ex, regOut_ex,
               Rs_id, Rt_id, usesRt_id, branch_taken_mem, jump_id, halt_wb,
        output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
               exmem_flush, memwb_en, halted, stall_count
    );

endinterface

// File: rtl/hazard_control_unit_stall_counter.sv
// Saturating event counter: counts enabled cycles and sticks at all-ones.
module stall_counter #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/hazard_control_unit.sv
// Stall/flush controller for the 5-stage pipeline: resolves halt, memory wait,
// taken branch, load-use and jump/fetch-miss hazards in strict priority order.
module hazard_control_unit
    import hazard_control_unit_pkg::*;
#(
    parameter int CNT_W = STALL_CNT_W,
    parameter int REG_W = REG_IDX_W
) (
    input logic                  CLK,
    input logic                  nRST,
    hazard_control_unit_if.slave hz
);

    hazard_state_t    state;
    hazard_state_t    next_state;
    logic [REG_W-1:0] dest_ex;
    logic             dwait;
    logic             load_use;

    assign dest_ex  = hz.regOut_ex;
    assign dwait    = (hz.dmemREN_mem | hz.dmemWEN_mem) & ~hz.dhit;
    assign load_use = hz.memToReg_ex && (dest_ex != '0) &&
                      ((hz.Rs_id == dest_ex) || (hz.usesRt_id && (hz.Rt_id == dest_ex)));

    // Hazards are re-evaluated every cycle; the state only remembers which one won.
    always_comb begin
        next_state     = RUN;
        hz.pc_en       = 1'b1;
        hz.ifid_en     = 1'b1;
        hz.ifid_flush  = 1'b0;
        hz.idex_en     = 1'b1;
        hz.idex_flush  = 1'b0;
        hz.exmem_en    = 1'b1;
        hz.exmem_flush = 1'b0;
        hz.memwb_en    = 1'b1;

        if ((state == HALTED) || hz.halt_wb) begin
            next_state  = HALTED;
            hz.pc_en    = 1'b0;
            hz.ifid_en  = 1'b0;
            hz.idex_en  = 1'b0;
            hz.exmem_en = 1'b0;
            hz.memwb_en = 1'b0;
        end else if (dwait) begin
            next_state  = DWAIT;
            hz.pc_en    = 1'b0;
            hz.ifid_en  = 1'b0;
            hz.idex_en  = 1'b0;
            hz.exmem_en = 1'b0;
            hz.memwb_en = 1'b0;
        end else if (hz.branch_taken_mem) begin
            // Squashes everything younger than MEM, including any load-use pair.
            next_state     = FLUSH;
            hz.ifid_flush  = 1'b1;
            hz.idex_flush  = 1'b1;
            hz.exmem_flush = 1'b1;
        end else if (load_use) begin
            next_state    = LSTALL;
            hz.pc_en      = 1'b0;
            hz.ifid_en    = 1'b0;
            hz.idex_flush = 1'b1;
        end else if (hz.jump_id) begin
            hz.ifid_flush = 1'b1;
        end else if (!hz.ihit) begin
            hz.pc_en      = 1'b0;
            hz.ifid_flush = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    assign hz.halted = (state == HALTED);

    stall_counter #(
        .CNT_W (CNT_W)
    ) u_stall_counter (
        .CLK   (CLK),
        .nRST  (nRST),
        .en    (!hz.pc_en && (state != HALTED)),
        .count (hz.stall_count)
    );

endmodule

// File: tb/tb_hazard_control_unit.sv
// Scoreboard bench for hazard_control_unit: directed hazard scenarios followed by
// random traffic, checked against a rule-level reference model.
module tb_hazard_control_unit;

    localparam int REG_W = 5;
    localparam int CNT_W = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic CLK = 1'b0;
    logic nRST;

    always #5 CLK = ~CLK;

    hazard_control_unit_if #(.REG_W(REG_W), .CNT_W(CNT_W)) hz ();

    hazard_control_unit #(
        .CNT_W (CNT_W),
        .REG_W (REG_W)
    ) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .hz   (hz)
    );

    typedef struct {
        logic             rst_n;
        logic             ihit;
        logic             dhit;
        logic             dren;
        logic             dwen;
        logic             mtr;
        logic [REG_W-1:0] reg_ex;
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic             uses_rt;
        logic             br;
        logic             jmp;
        logic             halt;
    } stim_t;

    typedef struct packed {
        logic [8:0]       ctrl;
        logic [CNT_W-1:0] count;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    bit   m_halted = 1'b0;
    int   m_count = 0;

    function automatic stim_t idle();
        stim_t s;
        s.rst_n = 1'b1;  s.ihit = 1'b1;  s.dhit = 1'b0;  s.dren = 1'b0;
        s.dwen = 1'b0;   s.mtr = 1'b0;   s.reg_ex = '0;  s.rs = '0;
        s.rt = '0;       s.uses_rt = 1'b0; s.br = 1'b0;  s.jmp = 1'b0;
        s.halt = 1'b0;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s.rst_n   = ($urandom_range(0, 24) != 0);
        s.ihit    = ($urandom_range(0, 3) != 0);
        s.dhit    = 1'($urandom_range(0, 1));
        s.dren    = ($urandom_range(0, 3) == 0);
        s.dwen    = ($urandom_range(0, 5) == 0);
        s.mtr     = 1'($urandom_range(0, 1));
        s.reg_ex  = REG_W'($urandom_range(0, 3));
        s.rs      = REG_W'($urandom_range(0, 3));
        s.rt      = REG_W'($urandom_range(0, 3));
        s.uses_rt = 1'($urandom_range(0, 1));
        s.br      = ($urandom_range(0, 5) == 0);
        s.jmp     = ($urandom_range(0, 5) == 0);
        s.halt    = ($urandom_range(0, 39) == 0);
        return s;
    endfunction

    // Order: pc_en ifid_en ifid_flush idex_en idex_flush exmem_en exmem_flush memwb_en halted
    function automatic exp_t predict(stim_t s);
        exp_t e;
        bit pc, ifen, iffl, iden, idfl, exen, exfl, wben;
        pc = 1; ifen = 1; iffl = 0; iden = 1; idfl = 0; exen = 1; exfl = 0; wben = 1;
        if (m_halted || s.halt) begin
            pc = 0; ifen = 0; iden = 0; exen = 0; wben = 0;
        end else if ((s.dren || s.dwen) && !s.dhit) begin
            pc = 0; ifen = 0; iden = 0; exen = 0; wben = 0;
        end else if (s.br) begin
            iffl = 1; idfl = 1; exfl = 1;
        end else if (s.mtr && s.reg_ex != 0 &&
                     (s.rs == s.reg_ex || (s.uses_rt && s.rt == s.reg_ex))) begin
            pc = 0; ifen = 0; idfl = 1;
        end else if (s.jmp) begin
            iffl = 1;
        end else if (!s.ihit) begin
            pc = 0; iffl = 1;
        end
        e.ctrl  = {pc, ifen, iffl, iden, idfl, exen, exfl, wben, m_halted};
        e.count = CNT_W'(m_count);
        return e;
    endfunction

    task automatic applyStimulus(input stim_t s);
        exp_t e;
        @(negedge CLK);
        #1;
        nRST                = s.rst_n;
        hz.ihit             = s.ihit;
        hz.dhit             = s.dhit;
        hz.dmemREN_mem      = s.dren;
        hz.dmemWEN_mem      = s.dwen;
        hz.memToReg_ex      = s.mtr;
        hz.regOut_ex        = s.reg_ex;
        hz.Rs_id            = s.rs;
        hz.Rt_id            = s.rt;
        hz.usesRt_id        = s.uses_rt;
        hz.branch_taken_mem = s.br;
        hz.jump_id          = s.jmp;
        hz.halt_wb          = s.halt;
        e = predict(s);
        sb.push_back(e);
        // Effect of the coming rising edge on the model.
        if (!s.rst_n) begin
            m_halted = 1'b0;
            m_count  = 0;
        end else begin
            if (!e.ctrl[8] && !m_halted && m_count < CNT_MAX) m_count++;
            if (s.halt) m_halted = 1'b1;
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        logic [8:0] act;
        e = sb.pop_front();
        act = {hz.pc_en, hz.ifid_en, hz.ifid_flush, hz.idex_en, hz.idex_flush,
               hz.exmem_en, hz.exmem_flush, hz.memwb_en, hz.halted};
        checks++;
        if (act !== e.ctrl) begin
            errors++;
            $display("[TB] FAIL ctrl at %0t: got %b expected %b", $time, act, e.ctrl);
        end
        checks++;
        if (hz.stall_count !== e.count) begin
            errors++;
            $display("[TB] FAIL stall_count at %0t: got %0d expected %0d",
                     $time, hz.stall_count, e.count);
        end
    endtask

    initial begin
        forever begin
            @(negedge CLK);
            #2;
            if (sb.size() > 0) checkOutput();
        end
    end

    initial begin
        stim_t s;
        nRST = 1'b0;
        s = idle();
        s.rst_n = 1'b0;
        applyStimulus(s);
        applyStimulus(s);
        applyStimulus(idle());

        // lw $5 in EX, ID reads rs=$5
        s = idle(); s.mtr = 1; s.reg_ex = 5; s.rs = 5;
        applyStimulus(s);
        applyStimulus(idle());
        // lw $0 never stalls
        s = idle(); s.mtr = 1; s.reg_ex = 0; s.rs = 0; s.rt = 0; s.uses_rt = 1;
        applyStimulus(s);
        // rt match matters only when rt is read
        s = idle(); s.mtr = 1; s.reg_ex = 7; s.rs = 3; s.rt = 7; s.uses_rt = 1;
        applyStimulus(s);
        s.uses_rt = 0;
        applyStimulus(s);

        // load waiting on memory for 3 cycles, then store waiting once
        s = idle(); s.dren = 1;
        repeat (3) applyStimulus(s);
        s.dhit = 1;
        applyStimulus(s);
        s = idle(); s.dwen = 1;
        applyStimulus(s);
        s.dhit = 1;
        applyStimulus(s);

        // branch beats load-use; memory wait beats branch
        s = idle(); s.br = 1; s.mtr = 1; s.reg_ex = 5; s.rs = 5;
        applyStimulus(s);
        applyStimulus(idle());
        s = idle(); s.br = 1; s.dren = 1;
        applyStimulus(s);
        s.dhit = 1;
        applyStimulus(s);

        s = idle(); s.jmp = 1;
        applyStimulus(s);
        s = idle(); s.ihit = 0;
        applyStimulus(s);
        s.jmp = 1;
        applyStimulus(s);

        // sticky halt held for 10 cycles under noisy inputs, then reset
        s = idle(); s.halt = 1;
        applyStimulus(s);
        for (int i = 0; i < 10; i++) begin
            s = rand_stim();
            s.rst_n = 1;
            applyStimulus(s);
        end
        s = idle(); s.rst_n = 0;
        applyStimulus(s);
        applyStimulus(idle());

        // saturation of the 4-bit counter
        s = idle(); s.ihit = 0;
        repeat (20) applyStimulus(s);
        applyStimulus(idle());
        s = idle(); s.rst_n = 0;
        applyStimulus(s);
        applyStimulus(idle());

        for (int i = 0; i < 400; i++) applyStimulus(rand_stim());

        repeat (2) @(negedge CLK);
        #3;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
